// File: rtl/block_map_ctrl.sv
// Tag table mapping backing-store blocks onto SRAM slots; handles misses by requesting a block swap.
// Latency: lookup is combinational; a miss costs a capture cycle, the swap (until done_i) and one update cycle.
// Backpressure: block_o stalls every requester while any valid channel misses or a swap is in flight.
module block_map_ctrl #(
  parameter int NumReq    = 2,
  parameter int NumSlots  = 4,
  parameter int AddrWidth = 21,
  parameter int Policy    = 0,
  parameter int SlotIdxW  = $clog2(NumSlots)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             valid_i,
  input  logic [NumReq-1:0]             write_i,
  input  logic [NumSlots-1:0]           pin_i,
  output logic [NumReq*SlotIdxW-1:0]    slot_idx_o,
  output logic [NumReq-1:0]             hit_o,
  output logic                          block_o,
  output logic                          swap_req_o,
  output logic [SlotIdxW-1:0]           swap_slot_o,
  output logic [AddrWidth-1:0]          old_addr_o,
  output logic [AddrWidth-1:0]          new_addr_o,
  output logic                          old_dirty_o,
  input  logic                          done_i
);

  typedef enum logic [1:0] {IDLE, SWAP, UPDATE} state_e;

  state_e                state_q;
  logic [NumSlots-1:0]   valid_q;
  logic [NumSlots-1:0]   dirty_q;
  logic [AddrWidth-1:0]  tag_q [NumSlots];
  logic [SlotIdxW-1:0]   age_q [NumSlots];
  logic [SlotIdxW-1:0]   rr_q;

  logic [NumReq-1:0]     match;
  logic [SlotIdxW-1:0]   match_slot [NumReq];
  logic [NumReq-1:0]     miss_vec;
  logic                  miss_any;
  logic [AddrWidth-1:0]  miss_addr;

  logic                  touch_en;
  logic [SlotIdxW-1:0]   touch_slot;
  logic [SlotIdxW-1:0]   touch_age;
  logic [NumSlots-1:0]   dirty_set;

  logic                  inv_found;
  logic [SlotIdxW-1:0]   inv_slot;
  logic                  pol_found;
  logic [SlotIdxW-1:0]   pol_slot;
  logic [SlotIdxW-1:0]   rr_idx;
  logic                  vic_found;
  logic [SlotIdxW-1:0]   vic_slot;
  logic                  vic_dirty;

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    match      = '0;
    hit_o      = '0;
    slot_idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      match_slot[i] = '0;
      for (int s = NumSlots - 1; s >= 0; s--) begin
        if (valid_q[s] && tag_q[s] == req_addr_i[i*AddrWidth +: AddrWidth]) begin
          match[i]      = 1'b1;
          match_slot[i] = SlotIdxW'(s);
        end
      end
      hit_o[i] = valid_i[i] & match[i];
      slot_idx_o[i*SlotIdxW +: SlotIdxW] = match_slot[i];
    end
  end

  assign miss_vec = valid_i & ~hit_o;
  assign miss_any = |miss_vec;
  assign block_o  = (state_q != IDLE) | (enable_i & miss_any);

  always_comb begin
    miss_addr = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (miss_vec[i]) miss_addr = req_addr_i[i*AddrWidth +: AddrWidth];
    end
  end

  // One age touch per cycle: lowest hitting channel in IDLE, the refilled slot in UPDATE.
  always_comb begin
    touch_en   = 1'b0;
    touch_slot = '0;
    dirty_set  = '0;
    if (state_q == IDLE && enable_i) begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (hit_o[i]) begin
          touch_en   = 1'b1;
          touch_slot = match_slot[i];
        end
      end
      for (int i = 0; i < NumReq; i++) begin
        if (hit_o[i] && write_i[i]) dirty_set[match_slot[i]] = 1'b1;
      end
    end else if (state_q == UPDATE) begin
      touch_en   = 1'b1;
      touch_slot = swap_slot_o;
    end
  end

  assign touch_age = age_q[touch_slot];

  // Victim: free unpinned slot first, then the configured replacement policy.
  always_comb begin
    inv_found = 1'b0;
    inv_slot  = '0;
    pol_found = 1'b0;
    pol_slot  = '0;
    rr_idx    = '0;
    for (int s = NumSlots - 1; s >= 0; s--) begin
      if (!valid_q[s] && !pin_i[s]) begin
        inv_found = 1'b1;
        inv_slot  = SlotIdxW'(s);
      end
    end
    if (Policy == 0) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (!pin_i[s] && (!pol_found || age_q[s] > age_q[pol_slot])) begin
          pol_found = 1'b1;
          pol_slot  = SlotIdxW'(s);
        end
      end
    end else begin
      for (int k = NumSlots - 1; k >= 0; k--) begin
        rr_idx = rr_q + SlotIdxW'(k);
        if (!pin_i[rr_idx]) begin
          pol_found = 1'b1;
          pol_slot  = rr_idx;
        end
      end
    end
    vic_found = inv_found | pol_found;
    vic_slot  = inv_found ? inv_slot : pol_slot;
  end

  assign vic_dirty = dirty_q[vic_slot] | dirty_set[vic_slot];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
      for (int s = 0; s < NumSlots; s++) begin
        tag_q[s] <= '0;
        age_q[s] <= SlotIdxW'(s);
      end
      swap_req_o  <= 1'b0;
      swap_slot_o <= '0;
      old_addr_o  <= '0;
      new_addr_o  <= '0;
      old_dirty_o <= 1'b0;
    end else begin
      dirty_q <= dirty_q | dirty_set;
      if (touch_en) begin
        for (int s = 0; s < NumSlots; s++) begin
          if (SlotIdxW'(s) == touch_slot) age_q[s] <= '0;
          else if (age_q[s] < touch_age) age_q[s] <= age_q[s] + SlotIdxW'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (enable_i && miss_any && vic_found) begin
            state_q     <= SWAP;
            swap_req_o  <= 1'b1;
            swap_slot_o <= vic_slot;
            old_addr_o  <= tag_q[vic_slot];
            new_addr_o  <= miss_addr;
            old_dirty_o <= valid_q[vic_slot] & vic_dirty;
            rr_q        <= vic_slot + SlotIdxW'(1);
          end
        end
        SWAP: begin
          if (done_i) begin
            swap_req_o <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          valid_q[swap_slot_o] <= 1'b1;
          tag_q[swap_slot_o]   <= new_addr_o;
          dirty_q[swap_slot_o] <= 1'b0;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_map_ctrl.sv
// Scoreboard bench: one LRU and one round-robin instance driven in parallel against a queue-based model.
module tb_block_map_ctrl;
  localparam int NR = 2;
  localparam int NS = 4;
  localparam int AW = 21;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              enable;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     valid, write;
  logic [NS-1:0]     pin;
  logic [1:0]        done;
  logic [NR*SW-1:0]  slot_idx [2];
  logic [NR-1:0]     hit [2];
  logic              block [2];
  logic              swap_req [2];
  logic [SW-1:0]     swap_slot [2];
  logic [AW-1:0]     old_addr [2];
  logic [AW-1:0]     new_addr [2];
  logic              old_dirty [2];

  block_map_ctrl #(.NumReq(NR), .NumSlots(NS), .AddrWidth(AW), .Policy(0)) u_lru (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .req_addr_i(req_addr),
    .valid_i(valid), .write_i(write), .pin_i(pin), .slot_idx_o(slot_idx[0]),
    .hit_o(hit[0]), .block_o(block[0]), .swap_req_o(swap_req[0]),
    .swap_slot_o(swap_slot[0]), .old_addr_o(old_addr[0]), .new_addr_o(new_addr[0]),
    .old_dirty_o(old_dirty[0]), .done_i(done[0]));

  block_map_ctrl #(.NumReq(NR), .NumSlots(NS), .AddrWidth(AW), .Policy(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .req_addr_i(req_addr),
    .valid_i(valid), .write_i(write), .pin_i(pin), .slot_idx_o(slot_idx[1]),
    .hit_o(hit[1]), .block_o(block[1]), .swap_req_o(swap_req[1]),
    .swap_slot_o(swap_slot[1]), .old_addr_o(old_addr[1]), .new_addr_o(new_addr[1]),
    .old_dirty_o(old_dirty[1]), .done_i(done[1]));

  typedef struct packed {
    logic [NR-1:0]    hit;
    logic [NR*SW-1:0] slot;
    logic             blk;
    logic             req;
  } lk_t;

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [AW-1:0] old_a;
    logic [AW-1:0] new_a;
    logic          dirty;
  } sw_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus state
  bit              en_v;
  bit [NR-1:0]     vld_v, wr_v;
  int unsigned     adr_v [NR];
  bit [NS-1:0]     pin_v;
  bit              allow_done;

  // Reference model: table contents, recency list (front = most recent), rr pointer, swap phase
  bit              m_val   [2][NS];
  bit              m_dirty [2][NS];
  int unsigned     m_tag   [2][NS];
  int              m_lru   [2][$];
  int              m_rr    [2];
  int              m_phase [2];
  int              m_vic   [2];
  int unsigned     m_new   [2];

  lk_t lk_q [2][$];
  sw_t sw_q [2][$];

  task automatic check(input string name, input int p, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %0h want %0h", name, p, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_lru[p].delete();
      for (int k = 0; k < NS; k++) begin
        m_val[p][k] = 0; m_dirty[p][k] = 0; m_tag[p][k] = 0;
        m_lru[p].push_back(k);
      end
      m_rr[p] = 0; m_phase[p] = 0; m_vic[p] = 0; m_new[p] = 0;
    end
  endtask

  task automatic lru_touch(input int p, input int s);
    int idx = 0;
    for (int k = 0; k < m_lru[p].size(); k++) if (m_lru[p][k] == s) idx = k;
    m_lru[p].delete(idx);
    m_lru[p].push_front(s);
  endtask

  // Instance 0 evicts least-recent, instance 1 rotates from its pointer.
  function automatic int pick(input int p);
    int v = -1;
    int s;
    for (int k = 0; k < NS; k++) if (v < 0 && !m_val[p][k] && !pin_v[k]) v = k;
    if (v < 0) begin
      if (p == 0) begin
        for (int k = NS - 1; k >= 0; k--) if (v < 0 && !pin_v[m_lru[p][k]]) v = m_lru[p][k];
      end else begin
        for (int k = 0; k < NS; k++) begin
          s = (m_rr[p] + k) % NS;
          if (v < 0 && !pin_v[s]) v = s;
        end
      end
    end
    return v;
  endfunction

  task automatic model_step(input int p);
    lk_t e;
    sw_t s;
    int mslot [NR];
    bit [NR-1:0] hitv;
    bit [NS-1:0] dset;
    int first_miss, vic, touch, ph;
    ph = m_phase[p];
    hitv = '0;
    first_miss = -1;
    for (int ch = 0; ch < NR; ch++) begin
      mslot[ch] = -1;
      for (int k = NS - 1; k >= 0; k--) if (m_val[p][k] && m_tag[p][k] == adr_v[ch]) mslot[ch] = k;
      hitv[ch] = vld_v[ch] && (mslot[ch] >= 0);
    end
    for (int ch = NR - 1; ch >= 0; ch--) if (vld_v[ch] && !hitv[ch]) first_miss = ch;
    e.hit  = hitv;
    e.slot = '0;
    for (int ch = 0; ch < NR; ch++) if (hitv[ch]) e.slot[ch*SW +: SW] = SW'(mslot[ch]);
    e.blk = (ph != 0) || (en_v && first_miss >= 0);
    e.req = (ph == 1);
    lk_q[p].push_back(e);
    if (ph == 0 && en_v) begin
      dset = '0;
      touch = -1;
      for (int ch = NR - 1; ch >= 0; ch--) if (hitv[ch]) touch = mslot[ch];
      for (int ch = 0; ch < NR; ch++) if (hitv[ch] && wr_v[ch]) dset[mslot[ch]] = 1'b1;
      if (first_miss >= 0) begin
        vic = pick(p);
        if (vic >= 0) begin
          s.slot  = SW'(vic);
          s.old_a = AW'(m_tag[p][vic]);
          s.new_a = AW'(adr_v[first_miss]);
          s.dirty = m_val[p][vic] && (m_dirty[p][vic] || dset[vic]);
          sw_q[p].push_back(s);
          m_vic[p]   = vic;
          m_new[p]   = adr_v[first_miss];
          m_rr[p]    = (vic + 1) % NS;
          m_phase[p] = 1;
        end
      end
      for (int k = 0; k < NS; k++) if (dset[k]) m_dirty[p][k] = 1;
      if (touch >= 0) lru_touch(p, touch);
    end else if (ph == 1) begin
      if (done[p]) m_phase[p] = 2;
    end else if (ph == 2) begin
      m_val[p][m_vic[p]]   = 1;
      m_tag[p][m_vic[p]]   = m_new[p];
      m_dirty[p][m_vic[p]] = 0;
      lru_touch(p, m_vic[p]);
      m_phase[p] = 0;
    end
  endtask

  function automatic bit all_hit(input int p);
    bit found;
    if (m_phase[p] != 0) return 0;
    for (int ch = 0; ch < NR; ch++) begin
      found = 0;
      for (int k = 0; k < NS; k++) if (m_val[p][k] && m_tag[p][k] == adr_v[ch]) found = 1;
      if (vld_v[ch] && !found) return 0;
    end
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      done[p] = allow_done && (m_phase[p] == 1) && ($urandom_range(0, 2) == 0);
    enable = en_v;
    valid  = vld_v;
    write  = wr_v;
    pin    = pin_v;
    for (int ch = 0; ch < NR; ch++) req_addr[ch*AW +: AW] = AW'(adr_v[ch]);
    model_step(0);
    model_step(1);
  endtask

  task automatic wait_hits(input string name, input int maxc);
    int c = 0;
    while (!(all_hit(0) && all_hit(1)) && c < maxc) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL %s: no hit within %0d cycles", name, c);
    end
    tick();
  endtask

  task automatic load(input int unsigned a);
    vld_v = 2'b01; wr_v = '0; adr_v[0] = a;
    wait_hits("load", 60);
  endtask

  // Monitor: per-cycle lookup expectations plus swap requests on their rising edge.
  lk_t mon_e;
  sw_t cur_sw [2];
  bit  prev_req [2];
  sw_t act_sw;

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (lk_q[p].size() > 0) begin
        mon_e = lk_q[p].pop_front();
        check("hit", p, 64'(hit[p]), 64'(mon_e.hit));
        for (int ch = 0; ch < NR; ch++)
          if (mon_e.hit[ch]) check("slot_idx", p, 64'(slot_idx[p][ch*SW +: SW]), 64'(mon_e.slot[ch*SW +: SW]));
        check("block", p, 64'(block[p]), 64'(mon_e.blk));
        check("swap_req_level", p, 64'(swap_req[p]), 64'(mon_e.req));
      end
      act_sw = {swap_slot[p], old_addr[p], new_addr[p], old_dirty[p]};
      if (swap_req[p] && !prev_req[p]) begin
        if (sw_q[p].size() == 0) begin
          check("swap_unexpected", p, 64'd1, 64'd0);
        end else begin
          cur_sw[p] = sw_q[p].pop_front();
          check("swap_slot", p, 64'(swap_slot[p]), 64'(cur_sw[p].slot));
          check("old_addr", p, 64'(old_addr[p]), 64'(cur_sw[p].old_a));
          check("new_addr", p, 64'(new_addr[p]), 64'(cur_sw[p].new_a));
          check("old_dirty", p, 64'(old_dirty[p]), 64'(cur_sw[p].dirty));
        end
      end else if (swap_req[p]) begin
        check("swap_stable", p, 64'(act_sw), 64'(cur_sw[p]));
      end
      prev_req[p] = swap_req[p];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 0; valid = '0; write = '0; pin = '0; done = '0; req_addr = '0;
    en_v = 0; vld_v = '0; wr_v = '0; pin_v = '0; allow_done = 0;
    for (int ch = 0; ch < NR; ch++) adr_v[ch] = 0;
    prev_req[0] = 0; prev_req[1] = 0;
    model_reset();
    #12;
    for (int p = 0; p < 2; p++) begin
      check("rst_swap_req", p, 64'(swap_req[p]), 64'd0);
      check("rst_block", p, 64'(block[p]), 64'd0);
      check("rst_hit", p, 64'(hit[p]), 64'd0);
      check("rst_fields", p, 64'({swap_slot[p], old_addr[p], new_addr[p], old_dirty[p]}), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // First miss: stall same cycle, swap to slot 0 next cycle, hit after update
    en_v = 1; vld_v = 2'b01; adr_v[0] = 'h10;
    tick();
    #1;
    for (int p = 0; p < 2; p++) check("first_block", p, 64'(block[p]), 64'd1);
    tick();
    #1;
    for (int p = 0; p < 2; p++) begin
      check("first_req", p, 64'(swap_req[p]), 64'd1);
      check("first_slot", p, 64'(swap_slot[p]), 64'd0);
      check("first_new", p, 64'(new_addr[p]), 64'h10);
      check("first_dirty", p, 64'(old_dirty[p]), 64'd0);
    end
    allow_done = 1;
    wait_hits("first_load", 40);
    #1;
    for (int p = 0; p < 2; p++) begin
      check("first_hit", p, 64'(hit[p][0]), 64'd1);
      check("first_unblock", p, 64'(block[p]), 64'd0);
    end

    // Fill, touch 0x10, then miss: LRU evicts slot 1, round-robin evicts slot 0
    load('h11); load('h12); load('h13); load('h10);
    allow_done = 0; adr_v[0] = 'h20;
    tick();
    tick();
    #1;
    check("lru_victim", 0, 64'(swap_slot[0]), 64'd1);
    check("lru_old_addr", 0, 64'(old_addr[0]), 64'h11);
    check("rr_victim", 1, 64'(swap_slot[1]), 64'd0);
    allow_done = 1;
    wait_hits("evict", 40);

    // Dirty tracking: written block is flagged on eviction, clean reload is not
    for (int r = 0; r < 2; r++) begin
      load('h40);
      vld_v = 2'b01; wr_v = (r == 0) ? 2'b01 : 2'b00; adr_v[0] = 'h40;
      tick();
      wr_v = '0;
      for (int a = 'h41; a <= 'h45; a++) load(a);
    end

    // Pinning: one pinned slot, then all pinned (stall without request), then release slot 2
    pin_v = 4'b0010; load('h71);
    pin_v = 4'hF; vld_v = 2'b01; adr_v[0] = 'h72; allow_done = 0;
    for (int c = 0; c < 4; c++) tick();
    #1;
    for (int p = 0; p < 2; p++) begin
      check("pinned_no_req", p, 64'(swap_req[p]), 64'd0);
      check("pinned_block", p, 64'(block[p]), 64'd1);
    end
    pin_v = 4'b1011;
    tick();
    tick();
    #1;
    for (int p = 0; p < 2; p++) check("unpin_slot", p, 64'(swap_slot[p]), 64'd2);
    allow_done = 1;
    wait_hits("unpin", 40);
    pin_v = '0;

    // Two channels miss together: lower channel first, stall until both hit
    vld_v = 2'b11; adr_v[0] = 'h30; adr_v[1] = 'h31;
    wait_hits("dual_miss", 80);

    // Enable dropped mid-swap: swap still completes
    vld_v = 2'b01; adr_v[0] = 'h60; allow_done = 0;
    tick();
    en_v = 0;
    tick();
    allow_done = 1;
    for (int c = 0; c < 30 && (m_phase[0] != 0 || m_phase[1] != 0); c++) tick();
    tick();
    tick();
    en_v = 1;

    // Reset mid-swap: request drops immediately, table is emptied
    vld_v = 2'b01; adr_v[0] = 'h50; allow_done = 0;
    tick();
    tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) check("rst_mid_req", p, 64'(swap_req[p]), 64'd0);
    done = '0; valid = '0; write = '0; enable = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    en_v = 0; vld_v = 2'b11; adr_v[0] = 'h10; adr_v[1] = 'h30;
    tick();
    #1;
    for (int p = 0; p < 2; p++) check("post_rst_hit", p, 64'(hit[p]), 64'd0);

    // Randomized traffic over a small address pool
    allow_done = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        vld_v = NR'($urandom_range(0, 3));
        wr_v  = NR'($urandom_range(0, 3));
        for (int ch = 0; ch < NR; ch++) adr_v[ch] = 'h10 + $urandom_range(0, 7);
      end
      en_v  = ($urandom_range(0, 15) != 0);
      pin_v = ($urandom_range(0, 4) == 0) ? NS'($urandom_range(0, 15)) : '0;
      tick();
    end

    // Drain outstanding swaps
    vld_v = '0; pin_v = '0; en_v = 1;
    for (int c = 0; c < 40 && (m_phase[0] != 0 || m_phase[1] != 0); c++) tick();
    tick();
    @(negedge clk);
    #1;
    for (int p = 0; p < 2; p++) check("swaps_outstanding", p, 64'(sw_q[p].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
